fetch_queue: RTL and testbench

- Instruction buffer between fetch and decode in the ppc core.
- Accepts one 64-bit fetch doubleword per cycle. The doubleword holds two big-endian 32-bit instructions.
- Presents instructions to decode one per cycle in program order, each tagged with its own PC.
- Decouples fetch from decode stalls and discards all buffered work on a redirect (flush).

---
 rtl/ppc_pkg.sv | 14 +
 rtl/fetch_queue_if.sv | 24 ++
 rtl/fq_ram.sv | 30 +++
 rtl/fetch_queue.sv | 68 ++++++
 tb/tb_fetch_queue.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/ppc_pkg.sv
// Shared types for the ppc front end: big-endian instruction, address and
// doubleword containers plus the fetch-queue entry layout.
package ppc_pkg;
    typedef logic [0:31] inst_t;
    typedef logic [0:63] addr_t;
    typedef logic [0:63] dword_t;

    localparam int INST_BYTES = 4;

    typedef struct packed {
        inst_t inst;
        addr_t pc;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch -> queue -> decode handshake bundle. master drives fetch data and
// consumes decode output; slave is the queue itself.
interface fetch_queue_if;
    import ppc_pkg::*;

    logic   in_valid;
    logic   in_ready;
    dword_t in_data;
    addr_t  in_pc;
    logic   out_valid;
    logic   out_ready;
    inst_t  out_inst;
    addr_t  out_pc;

    modport master (
        output in_valid, in_data, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc
    );

    modport slave (
        input  in_valid, in_data, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc
    );
endinterface

// File: rtl/fq_ram.sv
// Fetch-queue storage: two write ports hitting consecutive slots (wrapping)
// and one asynchronous read port.
module fq_ram
    import ppc_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             we0,
    input  logic             we1,
    input  logic [PTR_W-1:0] wa0,
    input  fq_entry_t        wd0,
    input  fq_entry_t        wd1,
    input  logic [PTR_W-1:0] ra,
    output fq_entry_t        rd
);
    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wa1;

    // Second port always lands one slot after the first, wrapping at DEPTH.
    assign wa1 = wa0 + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end

    assign rd = mem[ra];
endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: splits fetch doublewords into
// PC-tagged instructions and hands them to decode in program order.
module fetch_queue
    import ppc_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    fetch_queue_if.slave   fq,
    output logic [0:PTR_W] count
);
    localparam logic [PTR_W:0] MAX_FILL = (PTR_W+1)'(DEPTH - 2);

    logic [PTR_W-1:0] hd, tl;
    logic [PTR_W:0]   cnt;
    logic             pushOk, popOk, oddEntry;
    logic [PTR_W:0]   pushWords;
    addr_t            pcBase;
    fq_entry_t        word0, word1, wd0, rdEntry;

    assign fq.in_ready  = (cnt <= MAX_FILL);
    assign fq.out_valid = (cnt != '0);

    assign pushOk   = fq.in_valid & fq.in_ready & ~flush;
    assign popOk    = fq.out_valid & fq.out_ready & ~flush;
    assign oddEntry = fq.in_pc[61];

    always_comb begin
        pushWords = '0;
        if (pushOk) pushWords = oddEntry ? (PTR_W+1)'(1) : (PTR_W+1)'(2);
    end

    // A branch target on the odd word skips the lower instruction entirely.
    assign pcBase = {fq.in_pc[0:60], 3'b000};
    assign word0  = '{inst: fq.in_data[0:31],  pc: pcBase};
    assign word1  = '{inst: fq.in_data[32:63], pc: pcBase + 64'(INST_BYTES)};
    assign wd0    = oddEntry ? word1 : word0;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else begin
            tl  <= tl + pushWords[PTR_W-1:0];
            hd  <= hd + PTR_W'(popOk);
            cnt <= cnt + pushWords - (PTR_W+1)'(popOk);
        end
    end

    fq_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) uRam (
        .clk (clk),
        .we0 (pushOk),
        .we1 (pushOk & ~oddEntry),
        .wa0 (tl),
        .wd0 (wd0),
        .wd1 (word1),
        .ra  (hd),
        .rd  (rdEntry)
    );

    assign fq.out_inst = rdEntry.inst;
    assign fq.out_pc   = rdEntry.pc;
    assign count       = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, all checked
// against a queue-of-instructions reference model.
module tb_fetch_queue;
    import ppc_pkg::*;

    localparam int DEPTH = 64;
    localparam int PTR_W = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic [0:PTR_W] count;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .fq    (bus.slave),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];
    int   nAsserts = 0;
    int   nFails   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nAsserts++;
        assert (got === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs against the model, then advance.
    task automatic drive(input logic v, input logic [63:0] data, input logic [63:0] pc,
                         input logic ordy, input logic fl, input logic rstn);
        bit acc;
        bus.in_valid  = v;
        bus.in_data   = data;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        rst_n         = rstn;
        #1;
        chk("count", 64'(count), 64'(q.size()));
        chk("count_le_depth", 64'(count <= (PTR_W+1)'(DEPTH)), 64'd1);
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() <= DEPTH - 2));
        if (q.size() != 0) begin
            chk("out_inst", 64'(bus.out_inst), 64'(q[0].inst));
            chk("out_pc", 64'(bus.out_pc), q[0].pc);
        end
        if (!rstn || fl) begin
            q.delete();
        end else begin
            acc = v && (q.size() <= DEPTH - 2);
            if (ordy && q.size() != 0) void'(q.pop_front());
            if (acc) begin
                if (!pc[2]) q.push_back('{data[63:32], {pc[63:3], 3'b000}});
                q.push_back('{data[31:0], {pc[63:3], 3'b100}});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 64'd0, 64'd0, ordy, 1'b0, 1'b1);
    endtask

    task automatic push(input logic [63:0] data, input logic [63:0] pc, input logic ordy);
        drive(1'b1, data, pc, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        idle(1'b0);
        idle(1'b1);

        // basic aligned push and in-order drain
        push(64'h38600001_38800002, 64'h100, 1'b0);
        idle(1'b0);
        repeat (3) idle(1'b1);

        // odd-word entry
        push(64'hDEADBEEF_48000010, 64'h204, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // fill past full (extra pushes rejected), pop two, refill, drain across the wrap
        for (int i = 0; i < 34; i++)
            push({32'h1000_0000 + 32'(2*i), 32'h1000_0000 + 32'(2*i+1)}, 64'h1000 + 64'(8*i), 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        push(64'hAAAA0000_BBBB0000, 64'h2000, 1'b0);
        repeat (66) idle(1'b1);

        // simultaneous push and pop at count 3
        push(64'h11111111_22222222, 64'h400, 1'b0);
        push(64'h33333333_44444444, 64'h40C, 1'b0);
        push(64'h55555555_66666666, 64'h410, 1'b1);
        repeat (6) idle(1'b1);

        // push with pop at count 62, then rejected pushes at 63
        for (int i = 0; i < 31; i++)
            push({32'h2000_0000 + 32'(i), 32'h2100_0000 + 32'(i)}, 64'h8000 + 64'(8*i), 1'b0);
        push(64'h77777777_88888888, 64'h9000, 1'b1);
        push(64'h99999999_AAAAAAAA, 64'h9008, 1'b0);
        push(64'hBBBBBBBB_CCCCCCCC, 64'h9014, 1'b0);
        repeat (64) idle(1'b1);

        // reset mid-stream at count 5
        push(64'h01010101_02020202, 64'hA00, 1'b0);
        push(64'h03030303_04040404, 64'hA08, 1'b0);
        push(64'h05050505_06060606, 64'hA14, 1'b0);
        drive(1'b1, 64'h0F0F0F0F_0E0E0E0E, 64'hA18, 1'b1, 1'b0, 1'b0);
        idle(1'b0);

        // flush with a concurrent push at count 10, then restart at 0x300
        for (int i = 0; i < 5; i++)
            push({32'h3000_0000 + 32'(i), 32'h3100_0000 + 32'(i)}, 64'hB00 + 64'(8*i), 1'b0);
        drive(1'b1, 64'hFEEDFACE_CAFEF00D, 64'hC00, 1'b1, 1'b1, 1'b1);
        idle(1'b0);
        push(64'h60000000_60000001, 64'h300, 1'b0);
        repeat (3) idle(1'b1);

        // random traffic with phases biased toward filling or draining
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 120; c++) begin
                drive($urandom_range(0, 3) != 0,
                      {$urandom, $urandom},
                      {$urandom, $urandom},
                      (seg % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 60) == 0,
                      $urandom_range(0, 400) != 0);
            end
        end
        repeat (70) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
